// File: rtl/demux1_4_reg.sv
// rtl/demux1_4_reg.sv - registered 1-to-4 demultiplexer with per-channel valid/ack handshake
//
// One producer word (in_data) is steered by sel into one of four holding
// registers. Each channel stays FULL until its consumer acks it, which
// gives back-pressure per destination. Accepted writes are counted.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   producer presents in_data/sel
//   in_ready   write accepted this cycle (combinational on sel/out_valid/out_ack)
//   in_data    word to distribute
//   sel        destination channel 0..3
//   out_data   channel k at [k*WIDTH +: WIDTH]
//   out_valid  channel k holds an unconsumed word
//   out_ack    consumer k takes its word
//   xfer_cnt   accepted-transfer counter, wraps 255->0
//   err_ovw    sticky overwrite flag
//
// Optional feature macro: DEMUX1_4_OVERWRITE_EN
//   defined   : in_ready is always 1, writes to a FULL un-acked channel
//               overwrite it and set err_ovw until reset
//   undefined : back-pressure, err_ovw tied to 0

module demux1_4_reg #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         sel,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ack,
  output logic [7:0]         xfer_cnt,
  output logic               err_ovw
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q [4];
  state_t           state_d [4];
  logic [WIDTH-1:0] data_q  [4];
  logic             wr;
  logic [3:0]       wr_ch;

`ifdef DEMUX1_4_OVERWRITE_EN
  assign in_ready = 1'b1;
`else
  // A FULL destination can still accept when its word is consumed this cycle.
  assign in_ready = ~out_valid[sel] | out_ack[sel];
`endif

  // in_valid gates the write so sel is irrelevant while idle.
  assign wr = in_valid & in_ready;

  always_comb begin
    wr_ch = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      wr_ch[k] = wr && (sel == 2'(k));
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      state_d[k] = state_q[k];
      case (state_q[k])
        EMPTY: if (wr_ch[k]) state_d[k] = FULL;
        FULL: begin
          // A write wins over an ack: the old word is consumed, the new one held.
          if (!wr_ch[k] && out_ack[k]) state_d[k] = EMPTY;
        end
        default: state_d[k] = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= EMPTY;
        data_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= state_d[k];
        if (wr_ch[k]) data_q[k] <= in_data;
      end
    end
  end

  always_comb begin
    out_valid = 4'b0000;
    out_data  = '0;
    for (int k = 0; k < 4; k++) begin
      out_valid[k]                = (state_q[k] == FULL);
      out_data[k*WIDTH +: WIDTH]  = data_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= 8'd0;
    end else if (wr) begin
      xfer_cnt <= xfer_cnt + 8'd1;
    end
  end

`ifdef DEMUX1_4_OVERWRITE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovw <= 1'b0;
    end else if (|(wr_ch & out_valid & ~out_ack)) begin
      err_ovw <= 1'b1;
    end
  end
`else
  assign err_ovw = 1'b0;
`endif

endmodule

// File: tb/tb_demux1_4_reg.sv
// tb/tb_demux1_4_reg.sv - self-checking bench for demux1_4_reg
module tb_demux1_4_reg;

  localparam int WIDTH = 32;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [1:0]         sel;
  logic [4*WIDTH-1:0] out_data;
  logic [3:0]         out_valid;
  logic [3:0]         out_ack;
  logic [7:0]         xfer_cnt;
  logic               err_ovw;

  int checks = 0;
  int errors = 0;

  demux1_4_reg #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .sel(sel), .out_data(out_data), .out_valid(out_valid),
    .out_ack(out_ack), .xfer_cnt(xfer_cnt), .err_ovw(err_ovw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: four slots, each either holding a word or not.
  bit             m_full [4];
  logic [WIDTH-1:0] m_word [4];
  int             m_count;
  bit             m_err;
  bit             m_accept;

`ifdef DEMUX1_4_OVERWRITE_EN
  localparam bit OVW = 1'b1;
`else
  localparam bit OVW = 1'b0;
`endif

  // The producer is accepted if its slot is free, is being drained now, or overwrite is allowed.
  always_comb m_accept = in_valid && (OVW || !m_full[sel] || out_ack[sel]);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        m_full[k] <= 1'b0;
        m_word[k] <= '0;
      end
      m_count <= 0;
      m_err   <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (m_accept && int'(sel) == k) begin
          if (m_full[k] && !out_ack[k]) m_err <= 1'b1;
          m_full[k] <= 1'b1;
          m_word[k] <= in_data;
        end else if (out_ack[k]) begin
          m_full[k] <= 1'b0;
        end
      end
      if (m_accept) m_count <= (m_count + 1) % 256;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("valid%0d", k), 64'(out_valid[k]), 64'(m_full[k]));
        chk($sformatf("data%0d", k), 64'(out_data[k*WIDTH +: WIDTH]), 64'(m_word[k]));
      end
      chk("xfer_cnt", 64'(xfer_cnt), 64'(m_count));
      chk("err_ovw", 64'(err_ovw), 64'(m_err));
      if (in_valid) chk("in_ready", 64'(in_ready), 64'(m_accept));
    end
  end

  // Apply inputs now, then advance to 1 ns after the next rising edge.
  task automatic step(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] d, input logic [3:0] a);
    in_valid = v; sel = s; in_data = d; out_ack = a;
    @(posedge clk); #1;
  endtask

  initial begin
    int stalls;
    rst_n = 1'b0; in_valid = 1'b0; sel = 2'd0; in_data = '0; out_ack = 4'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 64'(out_valid), 64'h0);
    chk("reset_cnt", 64'(xfer_cnt), 64'h0);
    chk("reset_ready", 64'(in_ready), 64'h1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single write to channel 2.
    step(1'b1, 2'd2, 32'hDEADBEEF, 4'b0000);
    in_valid = 1'b0;
    chk("t1_valid", 64'(out_valid), 64'h4);
    chk("t1_data", 64'(out_data[95:64]), 64'hDEADBEEF);
    chk("t1_cnt", 64'(xfer_cnt), 64'h1);
    step(1'b0, 2'd0, '0, 4'b0100);

    // Back-pressure on a FULL channel, released by same-cycle ack.
    step(1'b1, 2'd1, 32'h11, 4'b0000);
    in_valid = 1'b1; sel = 2'd1; in_data = 32'h22; out_ack = 4'b0000;
    #1;
`ifndef DEMUX1_4_OVERWRITE_EN
    chk("t2_stall_ready", 64'(in_ready), 64'h0);
    @(posedge clk); #1;
    chk("t2_hold_data", 64'(out_data[63:32]), 64'h11);
`endif
    out_ack = 4'b0010;
    #1;
    chk("t2_ack_ready", 64'(in_ready), 64'h1);
    @(posedge clk); #1;
    chk("t2_new_data", 64'(out_data[63:32]), 64'h22);
    chk("t2_valid1", 64'(out_valid[1]), 64'h1);
    step(1'b0, 2'd0, '0, 4'b0010);

    // Write channel 0 while channel 3 is acked.
    step(1'b1, 2'd3, 32'h33, 4'b0000);
    in_valid = 1'b0;
    chk("t3_before", 64'(out_valid), 64'h8);
    step(1'b1, 2'd0, 32'h44, 4'b1000);
    in_valid = 1'b0;
    chk("t3_after", 64'(out_valid), 64'h1);
    step(1'b0, 2'd0, '0, 4'b0001);

    // Asynchronous reset pulse between edges discards pending words.
    step(1'b1, 2'd0, 32'h55, 4'b0000);
    step(1'b1, 2'd2, 32'h66, 4'b0000);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("t5_valid", 64'(out_valid), 64'h0);
    chk("t5_cnt", 64'(xfer_cnt), 64'h0);
    chk("t5_data", 64'(out_data), 64'h0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 256 back-to-back round-robin writes with every consumer acking.
    stalls = 0;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1; sel = 2'(i % 4); in_data = 32'(i * 7 + 1); out_ack = 4'b1111;
      #1;
      if (!in_ready) stalls++;
      @(posedge clk); #1;
    end
    chk("t4_stalls", 64'(stalls), 64'h0);
    chk("t4_cnt_wrap", 64'(xfer_cnt), 64'h0);
    chk("t4_last_data", 64'(out_data[127:96]), 64'(32'(255 * 7 + 1)));
    step(1'b0, 2'd0, '0, 4'b1111);
    chk("t4_drained", 64'(out_valid), 64'h0);

    // Write to a FULL channel without ack.
    step(1'b1, 2'd3, 32'hAA, 4'b0000);
    in_valid = 1'b1; sel = 2'd3; in_data = 32'hBB; out_ack = 4'b0000;
    #1;
`ifdef DEMUX1_4_OVERWRITE_EN
    chk("t6_ready", 64'(in_ready), 64'h1);
    @(posedge clk); #1;
    chk("t6_data", 64'(out_data[127:96]), 64'hBB);
    chk("t6_err", 64'(err_ovw), 64'h1);
    step(1'b0, 2'd0, '0, 4'b1000);
    step(1'b0, 2'd0, '0, 4'b1111);
    chk("t6_err_sticky", 64'(err_ovw), 64'h1);
    chk("t6_valid3", 64'(out_valid[3]), 64'h0);
`else
    chk("t6_ready", 64'(in_ready), 64'h0);
    @(posedge clk); #1;
    chk("t6_data", 64'(out_data[127:96]), 64'hAA);
    chk("t6_err", 64'(err_ovw), 64'h0);
    step(1'b0, 2'd0, '0, 4'b1000);
    chk("t6_valid3", 64'(out_valid[3]), 64'h0);
`endif

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
